dma_copy_master: RTL and testbench

DMA_COPY_MASTER -- requirements
Module: dma_copy_master

---
 rtl/dma_pkg.sv | 16 +
 rtl/bus_timeout_counter.sv | 44 ++++
 rtl/dma_copy_master.sv | 196 +++++++++++++++++++
 tb/tb_dma_copy_master.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA copy master: FSM state encoding and
// the byte-strobe patterns used to mark read and write requests.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } dma_state_e;

  // A read request carries no byte enables; a write covers the full word.
  localparam logic [3:0] C_RD = 4'b0000;
  localparam logic [3:0] C_WR = 4'b1111;

endpackage

// File: rtl/bus_timeout_counter.sv
// Per-transaction wait counter. Counts cycles while 'enable' is high and
// flags 'expired' on the LIMIT-th consecutive waiting cycle, so the owner
// can abandon the request on that same edge.
module bus_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
  localparam logic [CW-1:0] ONE  = CW'(32'd1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear wins, otherwise advance while waiting and saturate at LAST.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = {CW{1'b0}};
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/dma_copy_master.sv
// Word-by-word memory copy engine on a simple valid/ready bus. Each word is
// a read from the source followed by a write to the destination. All bus
// and status outputs are registered and derived from the next state, so
// they change only on clock edges and hold steady while a request stalls.
module dma_copy_master
  import dma_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 12,
  parameter int TIMEOUT = 255
) (
  input  logic              sys_clk,
  input  logic              sys_reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  word_cnt,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(32'd4);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;

  logic              in_xfer;
  logic              tmo_clear;
  logic              tmo_enable;
  logic              tmo_expired;

  // A request is outstanding in RD and WR only, so mem_ready elsewhere is ignored.
  assign in_xfer    = (state_q == RD) || (state_q == WR);
  assign tmo_enable = in_xfer && !mem_ready;
  assign tmo_clear  = !in_xfer || mem_ready;

  bus_timeout_counter #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk     (sys_clk),
    .rst     (sys_reset),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  // Next-state and datapath update for the copy sequencer.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (word_cnt != CNT_ZERO) begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            cnt_d   = word_cnt;
            state_d = RD;
          end else begin
            state_d = FIN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        if (mem_ready) begin
          data_d  = mem_rdata;
          state_d = WR;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          state_d = RD;
        end
      end
      WR: begin
        if (mem_ready) begin
          src_d   = src_q + ADDR_STEP;
          dst_d   = dst_q + ADDR_STEP;
          cnt_d   = cnt_q - CNT_ONE;
          state_d = (cnt_q == CNT_ONE) ? FIN : RD;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          state_d = WR;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered bus/status outputs, computed from the state being entered.
  always_comb begin
    mem_valid_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_d)
      RD: begin
        mem_valid_d = 1'b1;
        mem_addr_d  = src_d;
        mem_wstrb_d = C_RD;
        busy_d      = 1'b1;
      end
      WR: begin
        mem_valid_d = 1'b1;
        mem_addr_d  = dst_d;
        mem_wdata_d = data_d;
        mem_wstrb_d = C_WR;
        busy_d      = 1'b1;
      end
      FIN: begin
        done_d = 1'b1;
      end
      IDLE: begin
        mem_valid_d = 1'b0;
      end
      default: begin
        mem_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_q     <= IDLE;
      src_q       <= {ADDR_W{1'b0}};
      dst_q       <= {ADDR_W{1'b0}};
      cnt_q       <= CNT_ZERO;
      data_q      <= 32'h0000_0000;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= 32'h0000_0000;
      mem_wstrb_q <= 4'b0000;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_dma_copy_master.sv
// Bench for dma_copy_master: directed copies against a responder model.
// Expected bus transactions are queued when a copy is issued; a monitor
// pops and compares them whenever the DUT completes a bus handshake.
module tb_dma_copy_master;

  logic        sys_clk   = 1'b0;
  logic        sys_reset = 1'b1;
  logic        start     = 1'b0;
  logic [31:0] src_addr  = 32'h0;
  logic [31:0] dst_addr  = 32'h0;
  logic [11:0] word_cnt  = 12'h0;
  logic        busy, done, err, mem_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    bit          chk_wd;
  } txn_t;

  txn_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   resp_mode = 0;   // 0: ready one cycle after valid, 1: writes stall 5 extra cycles, 2: never ready
  int   wait_cnt = 0;

  always #5 sys_clk = ~sys_clk;

  dma_copy_master dut (
    .sys_clk   (sys_clk),
    .sys_reset (sys_reset),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .word_cnt  (word_cnt),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  // Memory content is a fixed function of the address.
  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1357};
  endfunction

  assign mem_rdata = mem_ready ? data_of(mem_addr) : 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    txn_t t;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = s + 32'(4 * i);
      t.addr = a;            t.wstrb = 4'h0; t.wdata = 32'h0;      t.chk_wd = 1'b0;
      sb_q.push_back(t);
      t.addr = d + 32'(4 * i); t.wstrb = 4'hF; t.wdata = data_of(a); t.chk_wd = 1'b1;
      sb_q.push_back(t);
    end
  endtask

  // Responder: acknowledges an outstanding request after a mode-dependent delay.
  always @(posedge sys_clk) begin
    if (resp_mode == 2 || !mem_valid || mem_ready) begin
      mem_ready <= 1'b0;
      wait_cnt  <= 0;
    end else if (wait_cnt >= ((resp_mode == 1 && mem_wstrb == 4'hF) ? 5 : 0)) begin
      mem_ready <= 1'b1;
      wait_cnt  <= 0;
    end else begin
      wait_cnt  <= wait_cnt + 1;
    end
  end

  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [31:0] prev_addr  = 32'h0;
  logic [31:0] prev_wdata = 32'h0;
  logic [3:0]  prev_wstrb = 4'h0;

  // Monitor: stall stability checks and scoreboard compare on each handshake.
  always @(negedge sys_clk) begin
    txn_t e;
    if (mem_valid && prev_valid && !prev_ready) begin
      check("hold_addr", mem_addr, prev_addr);
      check("hold_wdata", mem_wdata, prev_wdata);
      check("hold_wstrb", 32'(mem_wstrb), 32'(prev_wstrb));
    end
    if (mem_valid && mem_ready) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_txn: actual addr 0x%0h wstrb %b, required no transaction", mem_addr, mem_wstrb);
      end else begin
        e = sb_q.pop_front();
        check("txn_addr", mem_addr, e.addr);
        check("txn_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
        if (e.chk_wd) check("txn_wdata", mem_wdata, e.wdata);
      end
    end
    prev_valid <= mem_valid;
    prev_ready <= mem_ready;
    prev_addr  <= mem_addr;
    prev_wdata <= mem_wdata;
    prev_wstrb <= mem_wstrb;
  end

  // Issue one copy and wait (bounded) for done; report latency in cycles after the
  // start edge, valid-high cycles, done pulses, and busy/err one cycle after start.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [11:0] n,
                          input int max_cyc, output int lat, output int vcnt, output int dcnt,
                          output logic busy1, output logic err1);
    @(negedge sys_clk);
    src_addr = s; dst_addr = d; word_cnt = n; start = 1'b1;
    lat = 0; vcnt = 0; dcnt = 0; busy1 = 1'b0; err1 = 1'b0;
    do begin
      @(negedge sys_clk);
      start = 1'b0;
      lat++;
      if (mem_valid) vcnt++;
      if (lat == 1) begin busy1 = busy; err1 = err; end
    end while (!done && lat < max_cyc);
    if (done) begin
      dcnt = 1;
    end else begin
      tests++;
      fails++;
      $display("FAIL done_timeout: actual no done, required done within %0d cycles", max_cyc);
    end
    repeat (3) begin
      @(negedge sys_clk);
      if (done) dcnt++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual time limit reached, required bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, vc, dc, guard;
    logic b1, e1;

    // Reset state
    sys_reset = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_valid", 32'(mem_valid), 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_wstrb", 32'(mem_wstrb), 32'd0);
    sys_reset = 1'b0;

    // Basic 4-word copy, 1-cycle responder
    resp_mode = 0;
    push_copy(32'h0000_0000, 32'h0000_1000, 4);
    run_copy(32'h0000_0000, 32'h0000_1000, 12'd4, 60, lat, vc, dc, b1, e1);
    check_rng("t1_latency", lat, 16, 17);
    check("t1_busy_after_start", 32'(b1), 32'd1);
    check("t1_err", 32'(err), 32'd0);
    check("t1_done_pulses", 32'(dc), 32'd1);
    check("t1_busy_after_done", 32'(busy), 32'd0);
    check("t1_sb_empty", 32'(sb_q.size()), 32'd0);

    // Write stalls 5 cycles: hold checks in the monitor, 2*(2+7)+1 cycles latency
    resp_mode = 1;
    push_copy(32'h0000_0200, 32'h0000_0300, 2);
    run_copy(32'h0000_0200, 32'h0000_0300, 12'd2, 80, lat, vc, dc, b1, e1);
    check("t3_latency", 32'(lat), 32'd19);
    check("t3_err", 32'(err), 32'd0);
    check("t3_sb_empty", 32'(sb_q.size()), 32'd0);

    // No responder: valid for 255 cycles, then err and a single done
    resp_mode = 2;
    run_copy(32'h0000_0040, 32'h0000_0080, 12'd1, 400, lat, vc, dc, b1, e1);
    check("t4_valid_cycles", 32'(vc), 32'd255);
    check("t4_latency", 32'(lat), 32'd256);
    check("t4_err", 32'(err), 32'd1);
    check("t4_done_pulses", 32'(dc), 32'd1);
    check("t4_valid_after", 32'(mem_valid), 32'd0);

    // Zero-length copy: no bus traffic, done right away, err cleared
    resp_mode = 0;
    run_copy(32'h0000_0000, 32'h0000_0000, 12'd0, 10, lat, vc, dc, b1, e1);
    check_rng("t2_latency", lat, 1, 2);
    check("t2_valid_cycles", 32'(vc), 32'd0);
    check("t2_err_cleared", 32'(e1), 32'd0);
    check("t2_done_pulses", 32'(dc), 32'd1);

    // Source address wraps past the top of the address space
    push_copy(32'hFFFF_FFFC, 32'h0000_2000, 2);
    run_copy(32'hFFFF_FFFC, 32'h0000_2000, 12'd2, 40, lat, vc, dc, b1, e1);
    check("t5_latency", 32'(lat), 32'd9);
    check("t5_err", 32'(err), 32'd0);
    check("t5_sb_empty", 32'(sb_q.size()), 32'd0);

    // Start while busy is ignored; reset mid-copy aborts without done
    push_copy(32'h0000_0100, 32'h0000_0500, 2);
    @(negedge sys_clk);
    src_addr = 32'h0000_0100; dst_addr = 32'h0000_0500; word_cnt = 12'd3; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    src_addr = 32'h0000_0900; dst_addr = 32'h0000_0A00; word_cnt = 12'd1; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    check("t6_still_busy", 32'(busy), 32'd1);
    guard = 0;
    do begin
      @(negedge sys_clk);
      #1;
      guard++;
    end while (sb_q.size() != 0 && guard < 40);
    check("t6_sb_drained", 32'(sb_q.size()), 32'd0);
    sys_reset = 1'b1;
    @(negedge sys_clk);
    check("t6_rst_valid", 32'(mem_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    check("t6_rst_err", 32'(err), 32'd0);
    check("t6_rst_addr", mem_addr, 32'h0);
    check("t6_rst_wdata", mem_wdata, 32'h0);
    check("t6_rst_wstrb", 32'(mem_wstrb), 32'd0);
    @(negedge sys_clk);
    sys_reset = 1'b0;
    dc = 0;
    repeat (5) begin
      @(negedge sys_clk);
      if (done) dc++;
    end
    check("t6_no_done", 32'(dc), 32'd0);
    check("t6_idle_valid", 32'(mem_valid), 32'd0);
    check("t6_idle_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
